// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store bus adapter and the MEM-stage load aligner.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package lsu_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ    = 2'd1,
        WAIT_R = 2'd2,
        DONE   = 2'd3
    } lsu_state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    function automatic logic [3:0] be_gen(input logic [2:0] size, input logic [1:0] off);
        case (size)
            F3_B, F3_BU: be_gen = 4'b0001 << off;
            F3_H, F3_HU: be_gen = 4'b0011 << off;
            default:     be_gen = 4'b1111;
        endcase
    endfunction

    // Illegal funct3 encodings are reported through the same path as bad alignment.
    function automatic logic misaligned(input logic [2:0] size, input logic [1:0] off);
        case (size)
            F3_B, F3_BU: misaligned = 1'b0;
            F3_H, F3_HU: misaligned = off[0];
            F3_W:        misaligned = (off != 2'b00);
            default:     misaligned = 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Extracts the addressed byte/halfword from a bus word and sign- or zero-extends it.
// Latency: purely combinational.
// Backpressure: none; output follows inputs.
module lsu_load_align
    import lsu_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  off,
    input  logic [2:0]  funct3,
    output logic [31:0] ext
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rdata[7:0];
        case (off)
            2'd0: byte_sel = rdata[7:0];
            2'd1: byte_sel = rdata[15:8];
            2'd2: byte_sel = rdata[23:16];
            2'd3: byte_sel = rdata[31:24];
            default: byte_sel = rdata[7:0];
        endcase
        half_sel = off[1] ? rdata[31:16] : rdata[15:0];
    end

    always_comb begin
        ext = rdata;
        case (funct3)
            F3_B:    ext = {{24{byte_sel[7]}}, byte_sel};
            F3_BU:   ext = {24'h0, byte_sel};
            F3_H:    ext = {{16{half_sel[15]}}, half_sel};
            F3_HU:   ext = {16'h0, half_sel};
            default: ext = rdata;
        endcase
    end

endmodule

// File: rtl/lsu_bus_adapter.sv
// Turns core load/store accesses into req/gnt/rvalid word-bus transactions, stalling the core meanwhile.
// Latency: store stalls 2 cycles, load 3 cycles on a zero-wait bus; result valid in the single DONE cycle.
// Backpressure: bus outputs held stable until bus_gnt; Stall held until grant/response or timeout abort.
module lsu_bus_adapter
    import lsu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CNT_W          = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [2:0]  funct3,
    input  logic [31:0] ALUResult,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic        Stall,
    output logic        Misaligned,
    output logic        BusErr,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_gnt,
    input  logic        bus_rvalid,
    input  logic [31:0] bus_rdata
);

    localparam int              TO_M1   = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TO_M1);

    lsu_state_t       state, state_n;
    logic [CNT_W-1:0] cnt;
    logic             we_q;
    logic [29:0]      waddr_q;
    logic [3:0]       be_q;
    logic [31:0]      wdata_q;
    logic [2:0]       f3_q;
    logic [1:0]       off_q;
    logic [31:0]      rdata_q;
    logic             err_q;

    logic        access, bad, accept, capture, abort, to_hit, in_req;
    logic [31:0] wdata_rep, load_ext;

    assign access = MemRead | MemWrite;
    assign bad    = misaligned(funct3, ALUResult[1:0]);
    assign to_hit = (TIMEOUT_CYCLES != 0) && (cnt == TO_LAST);

    always_comb begin
        case (funct3[1:0])
            2'b00:   wdata_rep = {4{WriteData[7:0]}};
            2'b01:   wdata_rep = {2{WriteData[15:0]}};
            default: wdata_rep = WriteData;
        endcase
    end

    lsu_load_align u_align (
        .rdata  (bus_rdata),
        .off    (off_q),
        .funct3 (f3_q),
        .ext    (load_ext)
    );

    always_comb begin
        state_n    = state;
        Stall      = 1'b0;
        Misaligned = 1'b0;
        BusErr     = 1'b0;
        accept     = 1'b0;
        capture    = 1'b0;
        abort      = 1'b0;
        case (state)
            IDLE: begin
                if (access) begin
                    if (bad) begin
                        Misaligned = 1'b1;
                    end else begin
                        Stall   = 1'b1;
                        accept  = 1'b1;
                        state_n = REQ;
                    end
                end
            end
            REQ: begin
                Stall = 1'b1;
                if (bus_gnt) begin
                    state_n = we_q ? DONE : WAIT_R;
                end
                // A grant on the final budget cycle only completes a store; a load would overrun.
                if (to_hit && !(bus_gnt && we_q)) begin
                    state_n = DONE;
                    abort   = 1'b1;
                end
            end
            WAIT_R: begin
                Stall = 1'b1;
                if (bus_rvalid) begin
                    capture = 1'b1;
                    state_n = DONE;
                end else if (to_hit) begin
                    abort   = 1'b1;
                    state_n = DONE;
                end
            end
            DONE: begin
                BusErr  = err_q;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            we_q    <= 1'b0;
            waddr_q <= '0;
            be_q    <= '0;
            wdata_q <= '0;
            f3_q    <= '0;
            off_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state <= state_n;
            if (accept) begin
                cnt     <= '0;
                we_q    <= MemWrite;
                waddr_q <= ALUResult[31:2];
                be_q    <= be_gen(funct3, ALUResult[1:0]);
                wdata_q <= wdata_rep;
                f3_q    <= funct3;
                off_q   <= ALUResult[1:0];
                rdata_q <= '0;
                err_q   <= 1'b0;
            end else if (state == REQ || state == WAIT_R) begin
                cnt <= cnt + 1'b1;
            end
            if (capture) begin
                rdata_q <= load_ext;
            end
            if (abort) begin
                rdata_q <= '0;
                err_q   <= 1'b1;
            end
        end
    end

    assign in_req    = (state == REQ);
    assign bus_req   = in_req;
    assign bus_we    = in_req & we_q;
    assign bus_addr  = in_req ? {waddr_q, 2'b00} : 32'h0;
    assign bus_be    = in_req ? be_q : 4'h0;
    assign bus_wdata = in_req ? wdata_q : 32'h0;
    assign ReadData  = (state == DONE) ? rdata_q : 32'h0;

endmodule

// File: tb/tb_lsu_bus_adapter.sv
// Directed bench for lsu_bus_adapter: main instance with default timeout, second instance with a 4-cycle timeout.
module tb_lsu_bus_adapter;

    logic        clk, reset, MemRead, MemWrite;
    logic [2:0]  funct3;
    logic [31:0] ALUResult, WriteData;
    logic [31:0] ReadData, bus_addr, bus_wdata, bus_rdata;
    logic        Stall, Misaligned, BusErr, bus_req, bus_we, bus_gnt, bus_rvalid;
    logic [3:0]  bus_be;

    logic [31:0] t_ReadData, t_bus_addr, t_bus_wdata, t_rdata;
    logic        t_Stall, t_Misaligned, t_BusErr, t_bus_req, t_bus_we, t_gnt, t_rvalid;
    logic [3:0]  t_bus_be;

    int total, bad;

    int          r_stall;
    logic [31:0] r_rd, r_addr, r_wdata;
    logic [3:0]  r_be;
    logic        r_we, r_err, r_stable, r_done;

    lsu_bus_adapter dut (
        .clk(clk), .reset(reset), .MemRead(MemRead), .MemWrite(MemWrite), .funct3(funct3),
        .ALUResult(ALUResult), .WriteData(WriteData), .ReadData(ReadData), .Stall(Stall),
        .Misaligned(Misaligned), .BusErr(BusErr), .bus_req(bus_req), .bus_we(bus_we),
        .bus_addr(bus_addr), .bus_be(bus_be), .bus_wdata(bus_wdata), .bus_gnt(bus_gnt),
        .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata)
    );

    lsu_bus_adapter #(.TIMEOUT_CYCLES(4), .CNT_W(3)) dut_t (
        .clk(clk), .reset(reset), .MemRead(MemRead), .MemWrite(MemWrite), .funct3(funct3),
        .ALUResult(ALUResult), .WriteData(WriteData), .ReadData(t_ReadData), .Stall(t_Stall),
        .Misaligned(t_Misaligned), .BusErr(t_BusErr), .bus_req(t_bus_req), .bus_we(t_bus_we),
        .bus_addr(t_bus_addr), .bus_be(t_bus_be), .bus_wdata(t_bus_wdata), .bus_gnt(t_gnt),
        .bus_rvalid(t_rvalid), .bus_rdata(t_rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Drives one legal access and plays the bus side; results land in the r_* variables.
    task automatic do_access(input logic rd, input logic wr, input logic [2:0] f3,
                             input logic [31:0] addr, input logic [31:0] wd,
                             input int gnt_dly, input int rv_dly, input logic [31:0] rdv);
        int req_cyc, wait_cyc;
        @(negedge clk);
        MemRead = rd; MemWrite = wr; funct3 = f3; ALUResult = addr; WriteData = wd;
        bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = 32'h0;
        #1;
        r_stall = 0; r_done = 1'b0; r_stable = 1'b1; r_rd = 32'h0; r_err = 1'b0;
        r_we = 1'b0; r_addr = 32'h0; r_be = 4'h0; r_wdata = 32'h0;
        req_cyc = 0; wait_cyc = 0;
        for (int c = 0; c < 100 && !r_done; c++) begin
            if (Stall) begin
                r_stall++;
                if (bus_req) begin
                    if (req_cyc == 0) begin
                        r_we = bus_we; r_addr = bus_addr; r_be = bus_be; r_wdata = bus_wdata;
                    end else if ({bus_we, bus_addr, bus_be, bus_wdata} !== {r_we, r_addr, r_be, r_wdata}) begin
                        r_stable = 1'b0;
                    end
                    bus_gnt    = (req_cyc == gnt_dly);
                    bus_rvalid = !bus_gnt;          // stray rvalid while in REQ must be ignored
                    bus_rdata  = 32'hDEAD0000;
                    req_cyc++;
                end else if (c > 0) begin
                    bus_rvalid = (wait_cyc == rv_dly);
                    bus_rdata  = bus_rvalid ? rdv : 32'h0BAD0BAD;
                    wait_cyc++;
                end
            end else begin
                r_rd = ReadData; r_err = BusErr; r_done = 1'b1;
            end
            if (!r_done) begin
                @(negedge clk);
                bus_gnt = 1'b0; bus_rvalid = 1'b0;
                #1;
            end
        end
        MemRead = 1'b0; MemWrite = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        total++; if ({Stall, Misaligned, BusErr, bus_req, bus_we} !== 5'b0) begin bad++; $display("FAIL reset_flags: got %b want 00000", {Stall, Misaligned, BusErr, bus_req, bus_we}); end
        total++; if ({ReadData, bus_addr, bus_wdata, bus_be} !== 100'h0) begin bad++; $display("FAIL reset_data: got %h/%h/%h/%h want zeros", ReadData, bus_addr, bus_wdata, bus_be); end
        reset = 1'b0;
        @(negedge clk); #1;
        total++; if ({Stall, bus_req, t_Stall} !== 3'b0) begin bad++; $display("FAIL reset_idle: got %b want 000", {Stall, bus_req, t_Stall}); end
    endtask

    task automatic test_store_word;
        do_access(1'b0, 1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 0, 0, 32'h0);
        total++; if (r_done !== 1'b1) begin bad++; $display("FAIL sw_done: got %b want 1", r_done); end
        total++; if (r_stall != 2) begin bad++; $display("FAIL sw_stall: got %0d want 2", r_stall); end
        total++; if (r_we !== 1'b1 || r_be !== 4'b1111) begin bad++; $display("FAIL sw_we_be: got %b/%b want 1/1111", r_we, r_be); end
        total++; if (r_wdata !== 32'hDEADBEEF || r_addr !== 32'h100) begin bad++; $display("FAIL sw_data: got %h@%h want deadbeef@00000100", r_wdata, r_addr); end
        @(negedge clk); #1;
        total++; if ({Stall, bus_req} !== 2'b00) begin bad++; $display("FAIL sw_idle: got %b want 00", {Stall, bus_req}); end
    endtask

    task automatic test_loads;
        logic [2:0]  f3 [6];
        logic [31:0] ad [6];
        logic [31:0] rv [6];
        logic [31:0] ex [6];
        logic [3:0]  eb [6];
        f3 = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010, 3'b000};
        ad = '{32'h203, 32'h203, 32'h202, 32'h202, 32'h200, 32'h200};
        rv = '{32'h80FF1234, 32'h80FF1234, 32'h80FF1234, 32'h80FF1234, 32'h80FF1234, 32'h0000007F};
        ex = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF80FF, 32'h000080FF, 32'h80FF1234, 32'h0000007F};
        eb = '{4'b1000, 4'b1000, 4'b1100, 4'b1100, 4'b1111, 4'b0001};
        for (int i = 0; i < 6; i++) begin
            do_access(1'b1, 1'b0, f3[i], ad[i], 32'h0, 0, 0, rv[i]);
            total++; if (r_stall != 3) begin bad++; $display("FAIL load%0d_stall: got %0d want 3", i, r_stall); end
            total++; if (r_rd !== ex[i]) begin bad++; $display("FAIL load%0d_data: got %h want %h", i, r_rd, ex[i]); end
            total++; if (r_we !== 1'b0 || r_be !== eb[i] || r_addr !== 32'h200) begin bad++; $display("FAIL load%0d_bus: got we=%b be=%b addr=%h want 0/%b/00000200", i, r_we, r_be, r_addr, eb[i]); end
        end
    endtask

    task automatic test_store_steer;
        do_access(1'b0, 1'b1, 3'b000, 32'h101, 32'h000000A5, 0, 0, 32'h0);
        total++; if (r_be !== 4'b0010 || r_wdata !== 32'hA5A5A5A5 || r_addr !== 32'h100) begin bad++; $display("FAIL sb: got be=%b wdata=%h addr=%h want 0010/a5a5a5a5/00000100", r_be, r_wdata, r_addr); end
        total++; if (r_stall != 2) begin bad++; $display("FAIL sb_stall: got %0d want 2", r_stall); end
        do_access(1'b0, 1'b1, 3'b001, 32'h102, 32'h00001234, 0, 0, 32'h0);
        total++; if (r_be !== 4'b1100 || r_wdata !== 32'h12341234 || r_addr !== 32'h100) begin bad++; $display("FAIL sh: got be=%b wdata=%h addr=%h want 1100/12341234/00000100", r_be, r_wdata, r_addr); end
    endtask

    task automatic test_misaligned;
        logic [2:0]  f3 [3];
        logic [31:0] ad [3];
        logic        wr [3];
        logic        saw;
        f3 = '{3'b010, 3'b011, 3'b001};
        ad = '{32'h102, 32'h100, 32'h101};
        wr = '{1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            MemRead = !wr[i]; MemWrite = wr[i]; funct3 = f3[i]; ALUResult = ad[i]; WriteData = 32'hFFFF;
            #1;
            total++; if ({Misaligned, Stall, bus_req} !== 3'b100 || ReadData !== 32'h0) begin bad++; $display("FAIL mis%0d_pulse: got mis/stall/req=%b rd=%h want 100/0", i, {Misaligned, Stall, bus_req}, ReadData); end
            @(negedge clk);
            MemRead = 1'b0; MemWrite = 1'b0;
            #1;
            saw = Misaligned;
            for (int c = 0; c < 3; c++) begin
                saw = saw | bus_req | Stall;
                @(negedge clk); #1;
            end
            total++; if (saw !== 1'b0) begin bad++; $display("FAIL mis%0d_quiet: got activity=%b want 0", i, saw); end
        end
    endtask

    task automatic test_delayed;
        do_access(1'b1, 1'b0, 3'b101, 32'h200, 32'h0, 3, 1, 32'h5555ABCD);
        total++; if (r_stall != 7) begin bad++; $display("FAIL slow_stall: got %0d want 7", r_stall); end
        total++; if (r_stable !== 1'b1) begin bad++; $display("FAIL slow_stable: got %b want 1", r_stable); end
        total++; if (r_rd !== 32'h0000ABCD || r_err !== 1'b0) begin bad++; $display("FAIL slow_data: got %h err=%b want 0000abcd err=0", r_rd, r_err); end
        total++; if (r_be !== 4'b0011 || r_addr !== 32'h200) begin bad++; $display("FAIL slow_bus: got be=%b addr=%h want 0011/00000200", r_be, r_addr); end
    endtask

    task automatic test_back_to_back;
        do_access(1'b0, 1'b1, 3'b010, 32'h40, 32'h01020304, 0, 0, 32'h0);
        do_access(1'b1, 1'b0, 3'b000, 32'h41, 32'h0, 0, 0, 32'h0000C300);
        total++; if (r_rd !== 32'hFFFFFFC3 || r_stall != 3) begin bad++; $display("FAIL b2b_load: got %h stall=%0d want ffffffc3 stall=3", r_rd, r_stall); end
    endtask

    task automatic test_timeout;
        int  n, nreq;
        logic done, err, req;
        logic [31:0] rd;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        bus_gnt = 1'b0; bus_rvalid = 1'b0; t_gnt = 1'b0; t_rvalid = 1'b0;
        MemRead = 1'b1; MemWrite = 1'b0; funct3 = 3'b010; ALUResult = 32'h300;
        n = 0; nreq = 0; done = 1'b0; err = 1'b0; req = 1'b1; rd = 32'hFFFFFFFF;
        for (int c = 0; c < 20 && !done; c++) begin
            #1;
            if (t_Stall) begin
                n++;
                if (t_bus_req) nreq++;
            end else begin
                err = t_BusErr; rd = t_ReadData; req = t_bus_req; done = 1'b1;
            end
            if (!done) @(negedge clk);
        end
        MemRead = 1'b0;
        total++; if (done !== 1'b1 || n != 5 || nreq != 4) begin bad++; $display("FAIL to_cycles: got done=%b stall=%0d req=%0d want 1/5/4", done, n, nreq); end
        total++; if (err !== 1'b1 || rd !== 32'h0 || req !== 1'b0) begin bad++; $display("FAIL to_abort: got err=%b rd=%h req=%b want 1/0/0", err, rd, req); end
        @(negedge clk); #1;
        total++; if ({t_BusErr, t_Stall, t_bus_req} !== 3'b000) begin bad++; $display("FAIL to_idle: got %b want 000", {t_BusErr, t_Stall, t_bus_req}); end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset_mid;
        @(negedge clk);
        MemRead = 1'b1; funct3 = 3'b010; ALUResult = 32'h400; bus_gnt = 1'b0; bus_rvalid = 1'b0;
        @(negedge clk);
        #1;
        total++; if (bus_req !== 1'b1) begin bad++; $display("FAIL rst_req_pre: got %b want 1", bus_req); end
        reset = 1'b1; MemRead = 1'b0;
        @(negedge clk); #1;
        total++; if ({bus_req, Stall} !== 2'b00) begin bad++; $display("FAIL rst_req_drop: got %b want 00", {bus_req, Stall}); end
        reset = 1'b0;
        @(negedge clk);
        MemRead = 1'b1;
        @(negedge clk);
        bus_gnt = 1'b1;
        @(negedge clk);
        bus_gnt = 1'b0; MemRead = 1'b0;
        #1;
        total++; if ({Stall, bus_req} !== 2'b10) begin bad++; $display("FAIL rst_wait_pre: got %b want 10", {Stall, bus_req}); end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0; bus_rvalid = 1'b1; bus_rdata = 32'h12345678;
        #1;
        total++; if ({Stall, Misaligned, BusErr, bus_req, ReadData} !== 36'h0) begin bad++; $display("FAIL rst_wait_out: got flags=%b rd=%h want 0000/0", {Stall, Misaligned, BusErr, bus_req}, ReadData); end
        @(negedge clk);
        bus_rvalid = 1'b0;
        #1;
        total++; if ({Stall, BusErr, bus_req, ReadData} !== 35'h0) begin bad++; $display("FAIL rst_late_rvalid: got flags=%b rd=%h want 000/0", {Stall, BusErr, bus_req}, ReadData); end
    endtask

    initial begin
        total = 0; bad = 0;
        reset = 1'b1; MemRead = 1'b0; MemWrite = 1'b0; funct3 = 3'b0;
        ALUResult = 32'h0; WriteData = 32'h0;
        bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = 32'h0;
        t_gnt = 1'b0; t_rvalid = 1'b0; t_rdata = 32'h0;
        test_reset;
        test_store_word;
        test_loads;
        test_store_steer;
        test_misaligned;
        test_delayed;
        test_back_to_back;
        test_timeout;
        test_reset_mid;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
